// File: rtl/tia_bus_initiator.sv
// TIA register-bus initiator: queues host commands and drives one TIA access per strobe cycle.
// Optional RDY watchdog enabled by defining TIA_RDY_TIMEOUT_EN.
module tia_bus_initiator #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 456
) (
  input  logic        NTSC_Clk,
  input  logic        Reset,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic        Cmd_Write,
  input  logic [5:0]  Cmd_Addr,
  input  logic [7:0]  Cmd_Data,
  output logic [12:0] A,
  output logic        R,
  output logic [7:0]  D_Out,
  output logic        D_OE,
  input  logic [7:0]  D_In,
  input  logic        RDY,
  output logic        Rsp_Valid,
  output logic [7:0]  Rsp_Data,
  output logic        Busy,
  output logic        Timeout
);

  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [12:0] IdleAddr  = 13'h0080;
  localparam logic [5:0] WsyncAddr  = 6'h02;

  typedef enum logic [1:0] {StIdle, StStrobe, StRdWait, StGap} state_t;

  // Command queue
  logic            fifo_write [FIFO_DEPTH];
  logic [5:0]      fifo_addr  [FIFO_DEPTH];
  logic [7:0]      fifo_data  [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push, pop, full, pending;
  logic            head_write;
  logic [5:0]      head_addr;
  logic [7:0]      head_data;

  assign full       = (count_q == FullCnt);
  assign pending    = (count_q != '0);
  assign Cmd_Ready  = ~full;
  assign push       = Cmd_Valid & ~full;
  assign head_write = fifo_write[rd_ptr_q];
  assign head_addr  = fifo_addr[rd_ptr_q];
  assign head_data  = fifo_data[rd_ptr_q];

  always_ff @(posedge NTSC_Clk) begin
    if (push) begin
      fifo_write[wr_ptr_q] <= Cmd_Write;
      fifo_addr[wr_ptr_q]  <= Cmd_Addr;
      fifo_data[wr_ptr_q]  <= Cmd_Data;
    end
  end

  always_ff @(posedge NTSC_Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sequencer
  state_t      state_q;
  logic        cur_write_q;
  logic [5:0]  cur_addr_q;
  logic [12:0] a_q;
  logic        r_q, d_oe_q, rsp_valid_q;
  logic [7:0]  d_out_q, rsp_data_q;
  logic        issue_state, blocked, fire;

  // States in which the head command may be issued on this edge
  always_comb begin
    issue_state = 1'b0;
    case (state_q)
      StIdle, StRdWait: issue_state = 1'b1;
      StStrobe:         issue_state = cur_write_q & (cur_addr_q != WsyncAddr);
      default:          issue_state = 1'b0;
    endcase
  end

  assign blocked = issue_state & pending & ~RDY;
  assign pop     = issue_state & pending & (RDY | fire);

  always_ff @(posedge NTSC_Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      cur_write_q <= 1'b0;
      cur_addr_q  <= '0;
      a_q         <= IdleAddr;
      r_q         <= 1'b1;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      a_q         <= IdleAddr;
      r_q         <= 1'b1;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      if (state_q == StRdWait) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= D_In;
      end
      if (pop) begin
        state_q     <= StStrobe;
        cur_write_q <= head_write;
        cur_addr_q  <= head_addr;
        a_q         <= {7'b0, head_addr};
        r_q         <= ~head_write;
        d_oe_q      <= head_write;
        d_out_q     <= head_write ? head_data : 8'h00;
      end else begin
        case (state_q)
          StStrobe: begin
            if (!cur_write_q)                  state_q <= StRdWait;
            else if (cur_addr_q == WsyncAddr)  state_q <= StGap;
            else                               state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef TIA_RDY_TIMEOUT_EN
  localparam int unsigned TmoW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CYCLES);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            timeout_q;

  assign fire    = blocked & (tmo_cnt_q == TmoLimit);
  assign Timeout = timeout_q;

  always_ff @(posedge NTSC_Clk or posedge Reset) begin
    if (Reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= fire;
      if (RDY || fire || !pending) tmo_cnt_q <= '0;
      else if (blocked)            tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  logic unused_blocked;
  assign unused_blocked = blocked;
  assign fire           = 1'b0;
  assign Timeout        = 1'b0;
`endif

  assign A         = a_q;
  assign R         = r_q;
  assign D_Out     = d_out_q;
  assign D_OE      = d_oe_q;
  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Data  = rsp_data_q;
  assign Busy      = pending | (state_q != StIdle);

endmodule

// File: tb/tb_tia_bus_initiator.sv
// Bench for tia_bus_initiator: directed test-plan scenarios plus random traffic against a
// timeline/scoreboard model of the command stream.
module tb_tia_bus_initiator;

  localparam int unsigned DEPTH = 4;

  logic        NTSC_Clk, Reset;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Write;
  logic [5:0]  Cmd_Addr;
  logic [7:0]  Cmd_Data;
  logic [12:0] A;
  logic        R, D_OE, RDY, Rsp_Valid, Busy, Timeout;
  logic [7:0]  D_Out, D_In, Rsp_Data;

  tia_bus_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(456)) dut (
    .NTSC_Clk(NTSC_Clk), .Reset(Reset),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
    .Cmd_Addr(Cmd_Addr), .Cmd_Data(Cmd_Data),
    .A(A), .R(R), .D_Out(D_Out), .D_OE(D_OE), .D_In(D_In), .RDY(RDY),
    .Rsp_Valid(Rsp_Valid), .Rsp_Data(Rsp_Data), .Busy(Busy), .Timeout(Timeout)
  );

  initial NTSC_Clk = 1'b0;
  always #5 NTSC_Clk = ~NTSC_Clk;

  typedef struct packed {
    logic       write;
    logic [5:0] addr;
    logic [7:0] data;
  } cmd_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: pending commands plus the earliest edge each kind of access frees the bus
  cmd_t       q[$];
  int         next_free = 0;
  int         busy_until = 0;
  int         read_due = -1;
  logic [7:0] exp_rsp_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    next_free    = 0;
    busy_until   = 0;
    read_due     = -1;
    exp_rsp_data = 8'h00;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [5:0] a, input logic [7:0] d);
    Cmd_Valid = v;
    Cmd_Write = w;
    Cmd_Addr  = a;
    Cmd_Data  = d;
  endtask

  // One clock: advance the model on the edge, compare outputs 1 time unit later, return at negedge
  task automatic step();
    logic        push, issue, exp_rsp_valid, exp_r, exp_oe, chk_dout;
    logic [12:0] exp_a;
    logic [7:0]  exp_dout;
    cmd_t        c;
    @(posedge NTSC_Clk);
    cyc++;
    exp_rsp_valid = 1'b0;
    if (cyc == read_due) begin
      exp_rsp_valid = 1'b1;
      exp_rsp_data  = D_In;
    end
    push  = Cmd_Valid && (q.size() < DEPTH);
    issue = (q.size() != 0) && RDY && (cyc >= next_free);
    exp_a = 13'h0080; exp_r = 1'b1; exp_oe = 1'b0; exp_dout = 8'h00; chk_dout = 1'b1;
    if (issue) begin
      c = q.pop_front();
      exp_a = {7'd0, c.addr};
      if (c.write) begin
        exp_r = 1'b0; exp_oe = 1'b1; exp_dout = c.data;
        if (c.addr == 6'h02) begin
          next_free = cyc + 3; busy_until = cyc + 2;
        end else begin
          next_free = cyc + 1; busy_until = cyc + 1;
        end
      end else begin
        chk_dout = 1'b0;
        next_free = cyc + 2; busy_until = cyc + 2; read_due = cyc + 2;
      end
    end
    if (push) q.push_back('{write: Cmd_Write, addr: Cmd_Addr, data: Cmd_Data});
    #1;
    check_eq("bus_a", 32'(A), 32'(exp_a));
    check_eq("bus_r", 32'(R), 32'(exp_r));
    check_eq("bus_oe", 32'(D_OE), 32'(exp_oe));
    if (chk_dout) check_eq("bus_dout", 32'(D_Out), 32'(exp_dout));
    check_eq("rsp_valid", 32'(Rsp_Valid), 32'(exp_rsp_valid));
    check_eq("rsp_data", 32'(Rsp_Data), 32'(exp_rsp_data));
    check_eq("busy", 32'(Busy), 32'((q.size() != 0) || (cyc < busy_until)));
    check_eq("timeout", 32'(Timeout), 32'd0);
    @(negedge NTSC_Clk);
    check_eq("cmd_ready", 32'(Cmd_Ready), 32'(q.size() < DEPTH));
  endtask

  task automatic check_reset_bus(input string tag);
    check_eq({tag, "_a"}, 32'(A), 32'h0080);
    check_eq({tag, "_r"}, 32'(R), 32'd1);
    check_eq({tag, "_oe"}, 32'(D_OE), 32'd0);
    check_eq({tag, "_dout"}, 32'(D_Out), 32'd0);
    check_eq({tag, "_busy"}, 32'(Busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(Cmd_Ready), 32'd1);
    check_eq({tag, "_rspv"}, 32'(Rsp_Valid), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    RDY   = 1'b1;
    D_In  = 8'h00;
    set_cmd(1'b0, 1'b0, 6'h00, 8'h00);
    repeat (2) @(posedge NTSC_Clk);
    @(negedge NTSC_Clk);
    Reset = 1'b0;
    model_reset();
    #1;
    check_reset_bus("reset");
    check_eq("reset_rspdata", 32'(Rsp_Data), 32'd0);
    repeat (3) step();

    // Single write
    set_cmd(1'b1, 1'b1, 6'h09, 8'h1E); step();
    set_cmd(1'b0, 1'b0, 6'h00, 8'h00); repeat (4) step();

    // Three back-to-back writes
    set_cmd(1'b1, 1'b1, 6'h06, 8'h11); step();
    set_cmd(1'b1, 1'b1, 6'h07, 8'h22); step();
    set_cmd(1'b1, 1'b1, 6'h08, 8'h33); step();
    set_cmd(1'b0, 1'b0, 6'h00, 8'h00); repeat (4) step();

    // WSYNC then write, RDY low for 50 cycles after the gap
    set_cmd(1'b1, 1'b1, 6'h02, 8'h00); step();
    set_cmd(1'b1, 1'b1, 6'h09, 8'h5A); step();
    set_cmd(1'b0, 1'b0, 6'h00, 8'h00); step();
    RDY = 1'b0; repeat (50) step();
    RDY = 1'b1; repeat (4) step();

    // Read with collision data
    D_In = 8'hC0;
    set_cmd(1'b1, 1'b0, 6'h07, 8'hFF); step();
    set_cmd(1'b0, 1'b0, 6'h00, 8'h00); repeat (5) step();
    check_eq("read_data", 32'(Rsp_Data), 32'hC0);

    // Fill the queue under RDY stall, then reset mid-stall
    RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(1'b1, 1'b1, 6'(6'h10 + i), 8'(i));
      step();
    end
    check_eq("full_ready", 32'(Cmd_Ready), 32'd0);
    check_eq("full_busy", 32'(Busy), 32'd1);
    set_cmd(1'b0, 1'b0, 6'h00, 8'h00); step();
    Reset = 1'b1;
    #1;
    check_reset_bus("midreset");
    RDY = 1'b1;
    repeat (2) @(posedge NTSC_Clk);
    #1;
    check_eq("midreset_rspv_hold", 32'(Rsp_Valid), 32'd0);
    @(negedge NTSC_Clk);
    Reset = 1'b0;
    model_reset();
    repeat (3) step();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [5:0] ra;
      ra = ($urandom_range(0, 5) == 0) ? 6'h02 : 6'($urandom_range(0, 63));
      set_cmd(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), ra, 8'($urandom));
      RDY  = ($urandom_range(0, 3) != 0);
      D_In = 8'($urandom);
      step();
    end
    set_cmd(1'b0, 1'b0, 6'h00, 8'h00);
    RDY = 1'b1;
    repeat (20) step();
    check_eq("drain_busy", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
